// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receive framer and the transmitter.
//   rx_state_e : receive FSM states
//   PAR_*      : parity mode encodings (same wire encoding as the transmitter)
//   CPB_MIN*   : lowest usable clocks-per-bit, plain and with majority vote
//   rx_cfg_t   : per-frame configuration captured at start detection
//   exp_parity : expected parity bit for a received data word
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH
   } rx_state_e;

   localparam logic [1:0] PAR_SPACE = 2'b00;
   localparam logic [1:0] PAR_MARK  = 2'b01;
   localparam logic [1:0] PAR_EVEN  = 2'b10;
   localparam logic [1:0] PAR_ODD   = 2'b11;

   // Majority vote needs one sample either side of mid-bit inside the
   // half-bit window, hence the larger floor.
   localparam int CPB_MIN    = 4;
   localparam int CPB_MIN_MV = 6;

   typedef struct packed {
      logic       data_size;      // 0: 7 bits, 1: 8 bits
      logic       parity_en;
      logic [1:0] parity_mode;
      logic       stop_bit_size;  // 0: 1 stop, 1: 2 stops
   } rx_cfg_t;

   // In 7-bit mode the caller passes bit7 = 0, so it does not disturb parity.
   function automatic logic exp_parity(input logic [1:0] mode, input logic [7:0] d);
      logic p;
      case (mode)
         PAR_ODD:  p = ~^d;
         PAR_EVEN: p = ^d;
         PAR_MARK: p = 1'b1;
         default:  p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if -- one-entry valid/ready output stage of the UART receiver.
//   rx_data       received byte (bit7 = 0 in 7-bit mode)
//   rx_parity_err parity mismatch for rx_data
//   rx_frame_err  a stop bit sampled low for rx_data
//   rx_valid      rx_data and flags are valid
//   rx_ready      consumer accepts the word
// master: the receiver; slave: the consumer (RX FIFO).
interface uart_rx_frame_if;

   logic [7:0] rx_data;
   logic       rx_parity_err;
   logic       rx_frame_err;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, rx_parity_err, rx_frame_err, rx_valid,
                   input  rx_ready);
   modport slave  (input  rx_data, rx_parity_err, rx_frame_err, rx_valid,
                   output rx_ready);

endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler -- rx synchronizer, bit timer and sample decision.
//   clk, rst     system clock, async active-high reset
//   rx           raw asynchronous serial line
//   cpb          clamped clocks-per-bit used when a count is loaded
//   load_half    load floor(cpb/2) (start detection)
//   load_full    load a full bit (issued on the sample strobe)
//   run          framer is in a sampling state; timer idles otherwise
//   rxs          synchronized rx
//   smp_stb      one-cycle sample strobe
//   smp_bit      sampled bit, valid with smp_stb
// Option RX_MAJORITY_VOTE_EN: 2-of-3 vote over expiry-1..expiry+1, decided
// at expiry+1; full-bit reloads are one short so bit timing does not drift.
module uart_rx_sampler #(
   parameter int CPB_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic [CPB_WIDTH-1:0] cpb,
   input  logic                 load_half,
   input  logic                 load_full,
   input  logic                 run,
   output logic                 rxs,
   output logic                 smp_stb,
   output logic                 smp_bit
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CPB_WIDTH-1:0]   cnt_q;
   logic                   expire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
   end

   assign rxs    = sync_q[SYNC_STAGES-1];
   assign expire = run && (cnt_q == CPB_WIDTH'(1));

`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [CPB_WIDTH-1:0] FULL_ADJ = CPB_WIDTH'(1);

   logic rxs_d1, rxs_d2, pend_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxs_d1 <= 1'b1;
         rxs_d2 <= 1'b1;
         pend_q <= 1'b0;
      end else begin
         rxs_d1 <= rxs;
         rxs_d2 <= rxs_d1;
         pend_q <= expire && !load_half && !load_full;
      end
   end

   // Cycle after expiry: rxs_d2 = expiry-1, rxs_d1 = expiry, rxs = expiry+1.
   assign smp_stb = pend_q && run;
   assign smp_bit = (rxs_d2 & rxs_d1) | (rxs_d2 & rxs) | (rxs_d1 & rxs);
`else
   localparam logic [CPB_WIDTH-1:0] FULL_ADJ = '0;

   assign smp_stb = expire;
   assign smp_bit = rxs;
`endif

   // Down-counter; expiry is the cycle it reads 1. Stops at 0 so a late
   // (voted) decision cannot wrap it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 cnt_q <= '0;
      else if (load_half)      cnt_q <= cpb >> 1;
      else if (load_full)      cnt_q <= cpb - FULL_ADJ;
      else if (!run)           cnt_q <= '0;
      else if (cnt_q != '0)    cnt_q <= cnt_q - CPB_WIDTH'(1);
   end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame -- UART receive framer with one-entry valid/ready hold stage.
//   clk, rst        system clock, async active-high reset
//   rx              serial input, idle high
//   clocks_per_bit  clk cycles per bit (clamped to CPB_MIN / CPB_MIN_MV)
//   data_size, parity_en, parity_mode, stop_bit_size : frame format,
//                   captured at start detection
//   rx_if (master)  rx_data / rx_parity_err / rx_frame_err / rx_valid / rx_ready
//   overrun         one-cycle pulse: frame done while hold stage full, dropped
//   busy            FSM not in IDLE
// Option RX_MAJORITY_VOTE_EN: majority-vote sampling (see uart_rx_sampler).
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CPB_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic [CPB_WIDTH-1:0]  clocks_per_bit,
   input  logic                  data_size,
   input  logic                  parity_en,
   input  logic [1:0]            parity_mode,
   input  logic                  stop_bit_size,
   uart_rx_frame_if.master       rx_if,
   output logic                  overrun,
   output logic                  busy
);

`ifdef RX_MAJORITY_VOTE_EN
   localparam int CPB_CLAMP = CPB_MIN_MV;
`else
   localparam int CPB_CLAMP = CPB_MIN;
`endif

   rx_state_e            state_q, state_d;
   rx_cfg_t              cfg_q;
   logic [CPB_WIDTH-1:0] cpb_q, cpb_clamp, cpb_sel;
   logic [7:0]           shreg_q, data_w;
   logic [2:0]           bit_cnt_q, last_bit;
   logic                 par_err_q, frm_err_q, frm_err_w;
   logic                 rxs, smp_stb, smp_bit, run;
   logic                 load_half, load_full, cfg_cap, shift_en;
   logic                 par_chk, stop_chk, complete, take;

   assign cpb_clamp = (clocks_per_bit < CPB_WIDTH'(CPB_CLAMP)) ? CPB_WIDTH'(CPB_CLAMP)
                                                               : clocks_per_bit;
   // The start-detect load happens in the same cycle as config capture.
   assign cpb_sel   = (state_q == IDLE) ? cpb_clamp : cpb_q;
   assign run       = state_q inside {START, DATA, PARITY, STOP1, STOP2};
   assign busy      = (state_q != IDLE);

   uart_rx_sampler #(.CPB_WIDTH(CPB_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sampler (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .cpb       (cpb_sel),
      .load_half (load_half),
      .load_full (load_full),
      .run       (run),
      .rxs       (rxs),
      .smp_stb   (smp_stb),
      .smp_bit   (smp_bit)
   );

   // Bits arrive LSB first into bit7; a 7-bit word ends up in [7:1].
   assign data_w    = cfg_q.data_size ? shreg_q : {1'b0, shreg_q[7:1]};
   assign last_bit  = cfg_q.data_size ? 3'd7 : 3'd6;
   assign frm_err_w = frm_err_q | ~smp_bit;
   assign take      = ~rx_if.rx_valid | rx_if.rx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load_half = 1'b0;
      load_full = 1'b0;
      cfg_cap   = 1'b0;
      shift_en  = 1'b0;
      par_chk   = 1'b0;
      stop_chk  = 1'b0;
      complete  = 1'b0;
      case (state_q)
         IDLE: if (!rxs) begin
            state_d   = START;
            load_half = 1'b1;
            cfg_cap   = 1'b1;
         end
         START: if (smp_stb) begin
            if (smp_bit) state_d = IDLE;     // false start
            else begin
               state_d   = DATA;
               load_full = 1'b1;
            end
         end
         DATA: if (smp_stb) begin
            shift_en  = 1'b1;
            load_full = 1'b1;
            if (bit_cnt_q == last_bit) state_d = cfg_q.parity_en ? PARITY : STOP1;
         end
         PARITY: if (smp_stb) begin
            par_chk   = 1'b1;
            load_full = 1'b1;
            state_d   = STOP1;
         end
         STOP1: if (smp_stb) begin
            stop_chk = 1'b1;
            if (cfg_q.stop_bit_size) begin
               load_full = 1'b1;
               state_d   = STOP2;
            end else begin
               complete = 1'b1;
               state_d  = frm_err_w ? WAIT_HIGH : IDLE;
            end
         end
         STOP2: if (smp_stb) begin
            stop_chk = 1'b1;
            complete = 1'b1;
            state_d  = frm_err_w ? WAIT_HIGH : IDLE;
         end
         WAIT_HIGH: if (rxs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_q     <= '0;
         cpb_q     <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
      end else begin
         if (cfg_cap) begin
            cfg_q     <= '{data_size, parity_en, parity_mode, stop_bit_size};
            cpb_q     <= cpb_clamp;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
         end
         if (shift_en) begin
            shreg_q   <= {smp_bit, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
         end
         if (par_chk)             par_err_q <= (smp_bit != exp_parity(cfg_q.parity_mode, data_w));
         if (stop_chk && !smp_bit) frm_err_q <= 1'b1;
      end
   end

   // Hold stage: a completion during an accepting handshake reloads and
   // keeps rx_valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_if.rx_data       <= '0;
         rx_if.rx_parity_err <= 1'b0;
         rx_if.rx_frame_err  <= 1'b0;
         rx_if.rx_valid      <= 1'b0;
         overrun             <= 1'b0;
      end else begin
         if (complete && take) begin
            rx_if.rx_data       <= data_w;
            rx_if.rx_parity_err <= par_err_q;
            rx_if.rx_frame_err  <= frm_err_w;
            rx_if.rx_valid      <= 1'b1;
         end else if (rx_if.rx_valid && rx_if.rx_ready) begin
            rx_if.rx_valid <= 1'b0;
         end
         overrun <= complete && !take;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame -- scoreboard bench for uart_rx_frame. Stimulus pushes the
// expected word (derived from the frame format rules) when a frame is sent;
// a monitor pops and compares on every accepted rx_valid/rx_ready handshake.
module tb_uart_rx_frame;
   import uart_pkg::*;

`ifdef RX_MAJORITY_VOTE_EN
   localparam int CLAMP = CPB_MIN_MV;
`else
   localparam int CLAMP = CPB_MIN;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [15:0] clocks_per_bit = 16'd16;
   logic        data_size = 1'b1;
   logic        parity_en = 1'b0;
   logic [1:0]  parity_mode = PAR_SPACE;
   logic        stop_bit_size = 1'b0;
   logic        overrun, busy;

   uart_rx_frame_if rx_if();

   always #5 clk = ~clk;

   uart_rx_frame #(.CPB_WIDTH(16), .SYNC_STAGES(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx             (rx),
      .clocks_per_bit (clocks_per_bit),
      .data_size      (data_size),
      .parity_en      (parity_en),
      .parity_mode    (parity_mode),
      .stop_bit_size  (stop_bit_size),
      .rx_if          (rx_if),
      .overrun        (overrun),
      .busy           (busy)
   );

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0, n_fail = 0, n_words = 0, n_pushed = 0, ovr_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) tick();
   endtask

   // Expected word from the framing rules: data masked to the word size,
   // parity error only if a parity bit exists and was corrupted, frame error
   // if a stop bit was sent low.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit push);
      int         blen, nb;
      logic       ds, pen, sb2, p;
      logic [1:0] pm;
      logic [7:0] d;
      exp_t       e;
      blen = (int'(clocks_per_bit) < CLAMP) ? CLAMP : int'(clocks_per_bit);
      ds = data_size; pen = parity_en; pm = parity_mode; sb2 = stop_bit_size;
      nb = ds ? 8 : 7;
      d  = ds ? b : (b & 8'h7f);
      case (pm)
         PAR_ODD:  p = ($countones(d) % 2 == 0);
         PAR_EVEN: p = ($countones(d) % 2 == 1);
         PAR_MARK: p = 1'b1;
         default:  p = 1'b0;
      endcase
      e.d = d; e.pe = pen & bad_par; e.fe = bad_stop;
      if (push) begin
         sb.push_back(e);
         n_pushed++;
      end
      drive_bit(1'b0, blen);
      for (int i = 0; i < nb; i++) drive_bit(b[i], blen);
      if (pen) drive_bit(p ^ bad_par, blen);
      drive_bit(~bad_stop, blen);
      if (sb2) drive_bit(1'b1, blen);
      rx = 1'b1;
   endtask

   task automatic wait_drain(input string nm);
      int k = 0;
      while (sb.size() != 0 && k < 2000) begin
         tick();
         k++;
      end
      chk(nm, sb.size(), 0);
   endtask

   // Monitor: compare each accepted word against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (overrun) ovr_cnt++;
            if (rx_if.rx_valid && rx_if.rx_ready) begin
               n_words++;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word: got %0h expected none", rx_if.rx_data);
               end else begin
                  e = sb.pop_front();
                  chk("rx_data",       rx_if.rx_data,       e.d);
                  chk("rx_parity_err", rx_if.rx_parity_err, e.pe);
                  chk("rx_frame_err",  rx_if.rx_frame_err,  e.fe);
               end
            end
         end
      end
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: test did not finish in cycle budget");
      $fatal(1);
   end

   initial begin
      int w0, o0;
      rx_if.rx_ready = 1'b1;
      repeat (3) tick();
      chk("reset rx_valid", rx_if.rx_valid, 0);
      chk("reset rx_data",  rx_if.rx_data, 0);
      chk("reset errs",     {rx_if.rx_parity_err, rx_if.rx_frame_err}, 0);
      chk("reset overrun",  overrun, 0);
      chk("reset busy",     busy, 0);
      rst = 1'b0;
      repeat (4) tick();
      chk("idle busy", busy, 0);

      // 8N1 0x55
      send_frame(8'h55, 0, 0, 1);
      repeat (4) tick();

      // 7E2 0x41, good then bad parity
      data_size = 1'b0; parity_en = 1'b1; parity_mode = PAR_EVEN; stop_bit_size = 1'b1;
      send_frame(8'h41, 0, 0, 1);
      repeat (3) tick();
      send_frame(8'h41, 1, 0, 1);
      repeat (3) tick();
      wait_drain("drain 7E2");

      // Glitch: 5 low cycles is a false start
      data_size = 1'b1; parity_en = 1'b0; stop_bit_size = 1'b0;
      w0 = n_words;
      rx = 1'b0;
      repeat (5) tick();
      chk("glitch busy high", busy, 1);
      rx = 1'b1;
      repeat (20) tick();
      chk("glitch busy fell", busy, 0);
      chk("glitch no word", n_words, w0);

      // Frame error, line held low, then clean frame
      send_frame(8'hA3, 0, 1, 1);
      rx = 1'b0;
      repeat (48) tick();
      chk("wait_high busy", busy, 1);
      chk("no spurious word", n_words, n_pushed);
      rx = 1'b1;
      repeat (8) tick();
      chk("line high idle", busy, 0);
      send_frame(8'h3C, 0, 0, 1);
      repeat (4) tick();
      wait_drain("drain frame err");

      // Overrun
      rx_if.rx_ready = 1'b0;
      o0 = ovr_cnt;
      send_frame(8'h11, 0, 0, 1);
      repeat (3) tick();
      send_frame(8'h22, 0, 0, 0);
      repeat (4) tick();
      chk("overrun once", ovr_cnt, o0 + 1);
      chk("held word", rx_if.rx_data, 8'h11);
      chk("held valid", rx_if.rx_valid, 1);
      rx_if.rx_ready = 1'b1;
      repeat (2) tick();
      chk("valid cleared", rx_if.rx_valid, 0);

      // Mid-frame config change has no effect
      fork
         send_frame(8'h7E, 0, 0, 1);
         begin
            repeat (48) tick();
            parity_en = 1'b1;
         end
      join
      parity_en = 1'b0;
      repeat (4) tick();

      // Clocks-per-bit below the floor
      clocks_per_bit = 16'd1;
      send_frame(8'h96, 0, 0, 1);
      repeat (4) tick();
      wait_drain("drain directed");

      // Randomized formats
      for (int n = 0; n < 24; n++) begin
         clocks_per_bit = 16'($urandom_range(6, 20));
         data_size      = 1'($urandom_range(0, 1));
         parity_en      = 1'($urandom_range(0, 1));
         parity_mode    = 2'($urandom_range(0, 3));
         stop_bit_size  = 1'($urandom_range(0, 1));
         send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0), 1);
         repeat ($urandom_range(4, 9)) tick();
      end
      wait_drain("drain random");
      chk("random overruns", ovr_cnt, o0 + 1);

      // Async reset mid-frame with a word held
      clocks_per_bit = 16'd16; data_size = 1'b1; parity_en = 1'b0; stop_bit_size = 1'b0;
      rx_if.rx_ready = 1'b0;
      send_frame(8'h5A, 0, 0, 0);
      repeat (3) tick();
      chk("pre-reset valid", rx_if.rx_valid, 1);
      rx = 1'b0;
      repeat (48) tick();
      chk("pre-reset busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("async rst valid", rx_if.rx_valid, 0);
      chk("async rst data",  rx_if.rx_data, 0);
      chk("async rst errs",  {rx_if.rx_parity_err, rx_if.rx_frame_err}, 0);
      chk("async rst busy",  busy, 0);
      chk("async rst overrun", overrun, 0);
      rx = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("post-reset idle", busy, 0);
      rx_if.rx_ready = 1'b1;
      send_frame(8'hC3, 0, 0, 1);
      repeat (4) tick();
      wait_drain("drain final");
      chk("word count", n_words, n_pushed);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
